// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen_frac
// Purpose  : Fractional baud-rate generator. Produces an oversampling tick,
//            a mid-bit sample tick, a bit tick and a 50%-duty baud clock
//            from the system clock using an integer+fractional divisor.
//            The divisor is double-buffered so rate changes only take
//            effect on bit boundaries, sync strobes or while disabled.
// Ports    : clk            system clock, rising edge
//            rst_n          asynchronous active-low reset
//            i_en           generator enable
//            i_div_int      requested integer divisor
//            i_div_frac     requested fractional divisor (1/2^FRAC_W units)
//            i_div_load     strobe: capture requested divisor into shadow
//            i_sync         strobe: restart bit phase
//            o_os_tick      pulse at OVS x baud
//            o_mid_tick     pulse on the (OVS/2)-th os_tick of a bit
//            o_bit_tick     pulse on the OVS-th os_tick of a bit
//            o_baud_clk     square wave at the baud rate
//            o_div_pending  shadow holds a divisor not yet applied
// Revision : 1.0 - initial release
// ============================================================================
module baud_gen_frac #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 325,
    parameter int DEF_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    input  logic              i_sync,
    output logic              o_os_tick,
    output logic              o_mid_tick,
    output logic              o_bit_tick,
    output logic              o_baud_clk,
    output logic              o_div_pending
);

    localparam int                 c_OC_W     = $clog2(OVS);
    localparam logic [c_OC_W-1:0]  c_OC_MID   = c_OC_W'(OVS / 2 - 1);
    localparam logic [c_OC_W-1:0]  c_OC_LAST  = c_OC_W'(OVS - 1);
    localparam logic [DIV_W-1:0]   c_DIV_MIN  = DIV_W'(2);
    localparam logic [DIV_W-1:0]   c_DEF_INT  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0]  c_DEF_FRAC = FRAC_W'(DEF_FRAC);

    // Elaboration-time guard against unsupported configurations.
    if ((OVS != 8 && OVS != 16) || CLK_FREQ <= 0) begin : g_param_check
        $error("baud_gen_frac: OVS must be 8 or 16 and CLK_FREQ positive");
    end

    logic [DIV_W-1:0]  r_p;
    logic [FRAC_W-1:0] r_acc;
    logic [c_OC_W-1:0] r_oc;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_shd_int;
    logic [FRAC_W-1:0] r_shd_frac;
    logic              r_pending;
    logic              r_os_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;
    logic              r_baud_clk;

    logic [DIV_W-1:0]  w_int_clamped;
    logic [FRAC_W:0]   w_acc_sum;
    logic [DIV_W:0]    w_last;
    logic              w_wrap;
    logic              w_run;
    logic              w_bit;
    logic              w_apply;

    // Divisors 0 and 1 cannot produce a one-cycle tick pulse followed by a
    // low cycle, so the active divisor is floored at 2.
    assign w_int_clamped = (r_act_int < c_DIV_MIN) ? c_DIV_MIN : r_act_int;

    // Carry out of the fractional accumulator stretches the current interval
    // by one cycle. Terminal count is computed one bit wider so a full-scale
    // divisor plus carry never wraps.
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
    assign w_last    = {1'b0, w_int_clamped} - (DIV_W + 1)'(1)
                     + {{DIV_W{1'b0}}, w_acc_sum[FRAC_W]};
    assign w_wrap    = ({1'b0, r_p} == w_last);

    assign w_run   = i_en && !i_sync;
    assign w_bit   = w_run && w_wrap && (r_oc == c_OC_LAST);
    assign w_apply = !w_run || w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= '0;
            r_acc      <= '0;
            r_oc       <= '0;
            r_act_int  <= c_DEF_INT;
            r_act_frac <= c_DEF_FRAC;
            r_shd_int  <= c_DEF_INT;
            r_shd_frac <= c_DEF_FRAC;
            r_pending  <= 1'b0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
            r_baud_clk <= 1'b0;
        end else begin
            // Divisor double-buffering. A load presented on an apply cycle
            // bypasses the shadow so it is never left pending.
            if (w_apply) begin
                if (i_div_load) begin
                    r_act_int  <= i_div_int;
                    r_act_frac <= i_div_frac;
                    r_shd_int  <= i_div_int;
                    r_shd_frac <= i_div_frac;
                end else begin
                    r_act_int  <= r_shd_int;
                    r_act_frac <= r_shd_frac;
                end
                r_pending <= 1'b0;
            end else if (i_div_load) begin
                r_shd_int  <= i_div_int;
                r_shd_frac <= i_div_frac;
                r_pending  <= 1'b1;
            end

            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;

            if (!w_run) begin
                // Disabled or resynchronising: restart the bit from zero.
                r_p        <= '0;
                r_acc      <= '0;
                r_oc       <= '0;
                r_baud_clk <= 1'b0;
            end else if (w_wrap) begin
                r_p       <= '0;
                // Each bit restarts the fractional phase so that a divisor
                // applied at the bit boundary starts from a clean state.
                r_acc     <= w_bit ? '0 : w_acc_sum[FRAC_W-1:0];
                r_oc      <= r_oc + c_OC_W'(1);
                r_os_tick <= 1'b1;
                if (r_oc == c_OC_MID) begin
                    r_mid_tick <= 1'b1;
                    r_baud_clk <= 1'b1;
                end
                if (w_bit) begin
                    r_bit_tick <= 1'b1;
                    r_baud_clk <= 1'b0;
                end
            end else begin
                r_p <= r_p + DIV_W'(1);
            end
        end
    end

    assign o_os_tick     = r_os_tick;
    assign o_mid_tick    = r_mid_tick;
    assign o_bit_tick    = r_bit_tick;
    assign o_baud_clk    = r_baud_clk;
    assign o_div_pending = r_pending;

endmodule
`default_nettype wire
